game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Game flow controller: title/start/play/dying/clear/over sequencing, lives,
// level timer, gated movement commands and mp3 track selection.
module game_ctrl #(
   parameter int unsigned START_LIVES = 3,
   parameter int unsigned LEVEL_TIME  = 400,
   parameter int unsigned DEATH_TICKS = 30,
   parameter int unsigned CLEAR_TICKS = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_state,
   input  logic [8:0] key_ascii,
   input  logic       mario_dead,
   input  logic       mario_goal,
   output logic       left,
   output logic       right,
   output logic       jump,
   output logic       world_rst,
   output logic [2:0] phase,
   output logic [1:0] lives,
   output logic [8:0] time_left,
   output logic [1:0] track,
   output logic       play
);

   localparam logic [2:0] ST_TITLE = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_DYING = 3'd3;
   localparam logic [2:0] ST_CLEAR = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [8:0] TIME_INIT  = 9'(LEVEL_TIME);
   localparam logic [7:0] DEATH_N    = 8'(DEATH_TICKS);
   localparam logic [7:0] CLEAR_N    = 8'(CLEAR_TICKS);

   logic [2:0] state_q, state_d;
   logic [1:0] lives_q, lives_d;
   logic [8:0] time_q, time_d;
   logic [7:0] dwell_q, dwell_d;
   logic       key_prev_q, start_q;
   logic       left_q, right_q, jump_q;
   logic       left_d, right_d, jump_d;
   logic       s_key;
   logic [7:0] dwell_inc;

   assign s_key     = key_state && (key_ascii == 9'd83);
   assign dwell_inc = dwell_q + 8'd1;

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      // The previous-key sample follows the key even in reset, so an S held
      // across reset release is seen as already pressed.
      key_prev_q <= s_key;
      if (rst) begin
         state_q <= ST_TITLE;
         lives_q <= LIVES_INIT;
         time_q  <= 9'd0;
         dwell_q <= 8'd0;
         start_q <= 1'b0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         jump_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         time_q  <= time_d;
         dwell_q <= dwell_d;
         start_q <= s_key && !key_prev_q;
         left_q  <= left_d;
         right_q <= right_d;
         jump_q  <= jump_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      time_d  = time_q;
      dwell_d = dwell_q;
      case (state_q)
         ST_TITLE, ST_OVER: begin
            if (start_q) begin
               lives_d = LIVES_INIT;
               state_d = ST_START;
            end
         end
         ST_START: begin
            time_d  = TIME_INIT;
            dwell_d = 8'd0;
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (tick && (time_q != 9'd0)) time_d = time_q - 9'd1;
            if (mario_goal) begin
               state_d = ST_CLEAR;
               dwell_d = 8'd0;
            end else if (mario_dead || (time_q == 9'd0)) begin
               state_d = ST_DYING;
               dwell_d = 8'd0;
            end
         end
         ST_DYING: begin
            if (tick) begin
               dwell_d = dwell_inc;
               if (dwell_inc == DEATH_N) begin
                  lives_d = lives_q - 2'd1;
                  state_d = (lives_q == 2'd1) ? ST_OVER : ST_START;
               end
            end
         end
         ST_CLEAR: begin
            if (tick) begin
               dwell_d = dwell_inc;
               if (dwell_inc == CLEAR_N) state_d = ST_TITLE;
            end
         end
         default: state_d = ST_TITLE;
      endcase
   end

   // Movement is gated on the state being entered so it is never seen outside PLAY.
   always_comb begin
      left_d  = (state_d == ST_PLAY) && key_state && (key_ascii == 9'd65);
      right_d = (state_d == ST_PLAY) && key_state && (key_ascii == 9'd68);
      jump_d  = (state_d == ST_PLAY) && key_state && (key_ascii == 9'd87);
   end

   // Output decode from the registered state.
   always_comb begin
      world_rst = 1'b1;
      track     = 2'd0;
      play      = 1'b0;
      case (state_q)
         ST_TITLE: begin world_rst = 1'b1; track = 2'd0; play = 1'b0; end
         ST_START: begin world_rst = 1'b1; track = 2'd1; play = 1'b1; end
         ST_PLAY:  begin world_rst = 1'b0; track = 2'd1; play = 1'b1; end
         ST_DYING: begin world_rst = 1'b0; track = 2'd2; play = 1'b1; end
         ST_CLEAR: begin world_rst = 1'b0; track = 2'd3; play = 1'b1; end
         ST_OVER:  begin world_rst = 1'b1; track = 2'd2; play = 1'b1; end
         default:  begin world_rst = 1'b1; track = 2'd0; play = 1'b0; end
      endcase
   end

   assign phase     = state_q;
   assign lives     = lives_q;
   assign time_left = time_q;
   assign left      = left_q;
   assign right     = right_q;
   assign jump      = jump_q;

endmodule
